mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_rr_picker.sv | 27 ++
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the three-port memory arbiter.
// Port indices, FSM state encodings and the idle grant marker live here.
package mem_arbiter_pkg;

  localparam int NUM_PORTS = 3;

  localparam logic [1:0] PORT_FETCH = 2'd0;
  localparam logic [1:0] PORT_DATA  = 2'd1;
  localparam logic [1:0] PORT_DEBUG = 2'd2;
  localparam logic [1:0] GRANT_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Port index that follows p in round-robin order (wraps 2 -> 0).
  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == PORT_DEBUG) ? PORT_FETCH : p + 2'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: searches from last_grant+1 (mod 3)
// and returns the first requesting port.
module rr_picker
  import mem_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [1:0]           last_grant,
  output logic                 valid,
  output logic [1:0]           winner
);

  logic [1:0] cand;

  always_comb begin
    valid  = 1'b0;
    winner = PORT_FETCH;
    cand   = last_grant;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = next_port(cand);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-port round-robin arbiter in front of a single-port synchronous memory.
// One transaction at a time: IDLE (sample) -> ACCESS (drive memory) -> RESP (ack).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
  output logic [NUM_PORTS-1:0]          ack,
  output logic [DATA_W-1:0]             rdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_we,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy,
  output logic [1:0]                    grant_id
);

  state_t              state, state_next;
  logic [1:0]          last_grant;
  logic [1:0]          win_idx;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  logic                pick_valid;
  logic [1:0]          pick_idx;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  rr_picker u_picker (
    .req        (req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_idx)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int n = 0; n < NUM_PORTS; n++) begin
      if (pick_idx == n[1:0]) begin
        sel_we    = we[n];
        sel_addr  = addr[n*ADDR_W +: ADDR_W];
        sel_wdata = wdata[n*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (pick_valid) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= PORT_DEBUG;
      win_idx    <= PORT_FETCH;
      win_we     <= 1'b0;
      win_addr   <= '0;
      win_wdata  <= '0;
      rdata      <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && pick_valid) begin
        last_grant <= pick_idx;
        win_idx    <= pick_idx;
        win_we     <= sel_we;
        win_addr   <= sel_addr;
        win_wdata  <= sel_wdata;
      end
      if (state == ST_RESP) rdata <= mem_rdata;
    end
  end

  // Operand registers only change on a grant, so the memory bus holds outside ACCESS.
  assign mem_addr  = win_addr;
  assign mem_wdata = win_wdata;
  // Gated by reset so an aborted write never lands in memory.
  assign mem_we    = (state == ST_ACCESS) && win_we && !reset;

  always_comb begin
    ack = '0;
    for (int n = 0; n < NUM_PORTS; n++) begin
      if (state == ST_RESP && !reset && win_idx == n[1:0]) ack[n] = 1'b1;
    end
  end

  assign busy     = (state != ST_IDLE);
  assign grant_id = (state == ST_IDLE) ? GRANT_NONE : win_idx;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a read-first synchronous memory model.
// Each task drives one scenario and checks against hand-computed values.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req, we, ack;
  logic [23:0] addr;
  logic [47:0] wdata;
  logic [15:0] rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;
  logic        mem_we, busy;
  logic [1:0]  grant_id;

  logic [15:0] mem [256];
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.DATA_W(16), .ADDR_W(8)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic set_port(input int n, input logic w, input logic [7:0] a, input logic [15:0] d);
    we[n] = w;
    addr[n*8 +: 8] = a;
    wdata[n*16 +: 16] = d;
  endtask

  task automatic do_reset;
    reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    tick();
    tick();
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0h want 0", busy); end
    n_cmp++; if (grant_id !== 2'b11) begin n_err++; $display("FAIL reset_grant got %0h want 3", grant_id); end
    n_cmp++; if (ack !== 3'b000) begin n_err++; $display("FAIL reset_ack got %0h want 0", ack); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we got %0h want 0", mem_we); end
    n_cmp++; if (mem_addr !== 8'h00) begin n_err++; $display("FAIL reset_mem_addr got %0h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 16'h0000) begin n_err++; $display("FAIL reset_mem_wdata got %0h want 0", mem_wdata); end
    n_cmp++; if (rdata !== 16'h0000) begin n_err++; $display("FAIL reset_rdata got %0h want 0", rdata); end
    reset = 1'b0;
  endtask

  task automatic test_single_read;
    set_port(0, 1'b0, 8'h05, 16'h0000);
    req = 3'b001;
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rd_busy_access got %0h want 1", busy); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL rd_grant got %0h want 0", grant_id); end
    n_cmp++; if (mem_addr !== 8'h05) begin n_err++; $display("FAIL rd_mem_addr got %0h want 05", mem_addr); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rd_mem_we got %0h want 0", mem_we); end
    n_cmp++; if (ack !== 3'b000) begin n_err++; $display("FAIL rd_ack_early got %0h want 0", ack); end
    tick();
    n_cmp++; if (ack !== 3'b001) begin n_err++; $display("FAIL rd_ack got %0h want 1", ack); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rd_busy_resp got %0h want 1", busy); end
    req = 3'b000;
    tick();
    n_cmp++; if (rdata !== 16'h1234) begin n_err++; $display("FAIL rd_rdata got %0h want 1234", rdata); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rd_busy_idle got %0h want 0", busy); end
    n_cmp++; if (ack !== 3'b000) begin n_err++; $display("FAIL rd_ack_late got %0h want 0", ack); end
    n_cmp++; if (grant_id !== 2'b11) begin n_err++; $display("FAIL rd_grant_idle got %0h want 3", grant_id); end
  endtask

  task automatic test_write_read;
    set_port(1, 1'b1, 8'h10, 16'hBEEF);
    req = 3'b010;
    tick();
    n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL wr_mem_we got %0h want 1", mem_we); end
    n_cmp++; if (mem_addr !== 8'h10) begin n_err++; $display("FAIL wr_mem_addr got %0h want 10", mem_addr); end
    n_cmp++; if (mem_wdata !== 16'hBEEF) begin n_err++; $display("FAIL wr_mem_wdata got %0h want beef", mem_wdata); end
    n_cmp++; if (grant_id !== 2'd1) begin n_err++; $display("FAIL wr_grant got %0h want 1", grant_id); end
    tick();
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL wr_mem_we_resp got %0h want 0", mem_we); end
    n_cmp++; if (ack !== 3'b010) begin n_err++; $display("FAIL wr_ack got %0h want 2", ack); end
    req = 3'b000; we = 3'b000;
    tick();
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL wr_mem_we_idle got %0h want 0", mem_we); end
    n_cmp++; if (mem[8'h10] !== 16'hBEEF) begin n_err++; $display("FAIL wr_mem_content got %0h want beef", mem[8'h10]); end
    set_port(1, 1'b0, 8'h10, 16'h0000);
    req = 3'b010;
    tick();
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rb_mem_we got %0h want 0", mem_we); end
    tick();
    n_cmp++; if (ack !== 3'b010) begin n_err++; $display("FAIL rb_ack got %0h want 2", ack); end
    req = 3'b000;
    tick();
    n_cmp++; if (rdata !== 16'hBEEF) begin n_err++; $display("FAIL rb_rdata got %0h want beef", rdata); end
  endtask

  task automatic test_round_robin_all;
    logic [2:0] exp_ack;
    logic [1:0] exp_port [6];
    exp_port = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    do_reset();
    reset = 1'b0;
    req = 3'b111;
    for (int i = 1; i <= 18; i++) begin
      tick();
      exp_ack = 3'b000;
      if (i % 3 == 2) exp_ack[exp_port[(i - 2) / 3]] = 1'b1;
      n_cmp++; if (ack !== exp_ack) begin n_err++; $display("FAIL rr_all_ack cycle %0d got %0h want %0h", i, ack, exp_ack); end
      if (i % 3 == 1) begin
        n_cmp++; if (grant_id !== exp_port[(i - 1) / 3]) begin n_err++; $display("FAIL rr_all_grant cycle %0d got %0h want %0h", i, grant_id, exp_port[(i - 1) / 3]); end
      end
    end
    req = 3'b000;
    tick();
  endtask

  task automatic test_round_robin_skip;
    req = 3'b010;
    tick();
    n_cmp++; if (grant_id !== 2'd1) begin n_err++; $display("FAIL skip_grant1 got %0h want 1", grant_id); end
    tick();
    req = 3'b101;
    tick();
    tick();
    n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL skip_grant2 got %0h want 2", grant_id); end
    tick();
    n_cmp++; if (ack !== 3'b100) begin n_err++; $display("FAIL skip_ack2 got %0h want 4", ack); end
    req = 3'b001;
    tick();
    tick();
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL skip_grant0 got %0h want 0", grant_id); end
    tick();
    n_cmp++; if (ack !== 3'b001) begin n_err++; $display("FAIL skip_ack0 got %0h want 1", ack); end
    req = 3'b000;
    tick();
  endtask

  task automatic test_reset_abort;
    set_port(0, 1'b1, 8'h20, 16'hAAAA);
    req = 3'b001;
    tick();
    n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL abort_mem_we_pre got %0h want 1", mem_we); end
    reset = 1'b1;
    req = 3'b000;
    we = 3'b000;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL abort_mem_we_rst got %0h want 0", mem_we); end
    tick();
    reset = 1'b0;
    n_cmp++; if (ack !== 3'b000) begin n_err++; $display("FAIL abort_ack got %0h want 0", ack); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL abort_mem_we got %0h want 0", mem_we); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %0h want 0", busy); end
    n_cmp++; if (grant_id !== 2'b11) begin n_err++; $display("FAIL abort_grant got %0h want 3", grant_id); end
    n_cmp++; if (mem[8'h20] !== 16'h5555) begin n_err++; $display("FAIL abort_mem got %0h want 5555", mem[8'h20]); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (ack !== 3'b000) begin n_err++; $display("FAIL abort_ack_after cycle %0d got %0h want 0", i, ack); end
    end
  endtask

  task automatic test_drop_during_access;
    set_port(2, 1'b0, 8'h30, 16'h0000);
    set_port(0, 1'b0, 8'h05, 16'h0000);
    req = 3'b100;
    tick();
    n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL drop_grant got %0h want 2", grant_id); end
    req = 3'b000;
    tick();
    n_cmp++; if (ack !== 3'b100) begin n_err++; $display("FAIL drop_ack got %0h want 4", ack); end
    req = 3'b001;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_busy got %0h want 0", busy); end
    n_cmp++; if (grant_id !== 2'b11) begin n_err++; $display("FAIL drop_no_grant got %0h want 3", grant_id); end
    n_cmp++; if (rdata !== 16'h7777) begin n_err++; $display("FAIL drop_rdata got %0h want 7777", rdata); end
    tick();
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL drop_next_grant got %0h want 0", grant_id); end
    tick();
    n_cmp++; if (ack !== 3'b001) begin n_err++; $display("FAIL drop_next_ack got %0h want 1", ack); end
    req = 3'b000;
    tick();
    n_cmp++; if (rdata !== 16'h1234) begin n_err++; $display("FAIL drop_next_rdata got %0h want 1234", rdata); end
  endtask

  initial begin
    reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    load(8'h00, 16'h0000);
    load(8'h05, 16'h1234);
    load(8'h10, 16'h0000);
    load(8'h20, 16'h5555);
    load(8'h30, 16'h7777);
    test_reset();
    test_single_read();
    test_write_read();
    test_round_robin_all();
    test_round_robin_skip();
    test_reset_abort();
    test_drop_during_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
